// File: rtl/flag_interrupt_ctrl.sv
// Interrupt sequencer: samples flags/IRQs, saves PC and flags, vectors to the handler,
// and restores both on RETI through the flag register's full-vector load path.
module flag_interrupt_ctrl #(
   parameter int               PCW        = 8,
   parameter int               NIRQ       = 4,
   parameter logic [PCW-1:0]   VEC_BASE   = 8'hF0,
   parameter int               VEC_STRIDE = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          flags,
   input  logic [NIRQ-1:0]     irq_in,
   input  logic                reti,
   input  logic [PCW-1:0]      pc_in,
   output logic                stall,
   output logic                pc_load,
   output logic [PCW-1:0]      pc_out,
   output logic                flag_wr,
   output logic [7:0]          flag_value,
   output logic [NIRQ-1:0]     irq_ack,
   output logic                busy
);

   localparam int SELW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SAVE    = 3'd1;
   localparam logic [2:0] ST_VECTOR  = 3'd2;
   localparam logic [2:0] ST_ACTIVE  = 3'd3;
   localparam logic [2:0] ST_RESTORE = 3'd4;

   logic [2:0]      state_reg, state_next;
   logic [NIRQ-1:0] pending_reg, pending_next;
   logic [NIRQ-1:0] req, sel_onehot, clr;
   logic [SELW-1:0] sel_reg, winner;
   logic [7:0]      saved_flags_reg;
   logic [7:0]      flag_hold_reg;
   logic [PCW-1:0]  saved_pc_reg;
   logic [PCW-1:0]  vec_addr;
   logic            unused_saved_hi;

   // Upper saved bits are overwritten on every write-back, so they are never read.
   assign unused_saved_hi = ^saved_flags_reg[7:5];

   assign req = pending_reg | irq_in;

   // Lowest set index wins: scan from the top so the last hit is the lowest.
   always_comb begin
      winner = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner = SELW'(i);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NIRQ; gi++) begin : g_sel
         assign sel_onehot[gi] = (sel_reg == SELW'(gi));
      end
   endgenerate

   assign clr          = (state_reg == ST_SAVE) ? sel_onehot : '0;
   assign pending_next = (pending_reg & ~clr) | irq_in;
   assign vec_addr     = VEC_BASE + PCW'(32'(sel_reg) * 32'(VEC_STRIDE));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (flags[4] && (req != '0)) state_next = ST_SAVE;
         ST_SAVE:    state_next = ST_VECTOR;
         ST_VECTOR:  state_next = ST_ACTIVE;
         ST_ACTIVE:  if (reti) state_next = ST_RESTORE;
         ST_RESTORE: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         pending_reg     <= '0;
         saved_flags_reg <= 8'h20;
         saved_pc_reg    <= '0;
         sel_reg         <= '0;
         flag_hold_reg   <= 8'h20;
      end else begin
         state_reg     <= state_next;
         pending_reg   <= pending_next;
         flag_hold_reg <= flag_value;
         if ((state_reg == ST_IDLE) && (state_next == ST_SAVE)) begin
            saved_flags_reg <= flags;
            saved_pc_reg    <= pc_in;
            sel_reg         <= winner;
         end
      end
   end

   // Outputs depend on state and registers only; flag_value holds between writes.
   always_comb begin
      stall      = 1'b0;
      pc_load    = 1'b0;
      pc_out     = '0;
      flag_wr    = 1'b0;
      flag_value = flag_hold_reg;
      irq_ack    = '0;
      busy       = (state_reg != ST_IDLE);
      case (state_reg)
         ST_SAVE: begin
            stall   = 1'b1;
            irq_ack = sel_onehot;
         end
         ST_VECTOR: begin
            stall      = 1'b1;
            pc_load    = 1'b1;
            pc_out     = vec_addr;
            flag_wr    = 1'b1;
            flag_value = {2'b00, 1'b1, 1'b0, saved_flags_reg[3:0]};
         end
         ST_RESTORE: begin
            stall      = 1'b1;
            pc_load    = 1'b1;
            pc_out     = saved_pc_reg;
            flag_wr    = 1'b1;
            flag_value = {2'b00, 1'b1, saved_flags_reg[4:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_flag_interrupt_ctrl.sv
// Scoreboard bench for flag_interrupt_ctrl: a transaction-level model predicts
// acknowledge / vector / restore events; a separate monitor checks them.
module tb_flag_interrupt_ctrl;

   localparam int BIG = 32'h7fff_ffff;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       reti = 1'b0;
   logic [7:0] flags = 8'h20;
   logic [7:0] pc_in = 8'h00;
   logic [3:0] irq_in = 4'h0;
   logic       stall, pc_load, flag_wr, busy;
   logic [7:0] pc_out, flag_value;
   logic [3:0] irq_ack;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [3:0] ack;
      logic       ld;
      logic [7:0] pc;
      logic       wr;
      logic [7:0] fv;
   } ev_t;

   typedef struct {
      int   cyc;
      logic busy;
   } st_t;

   ev_t exp_q[$];
   st_t st_q[$];

   // reference model state
   logic [3:0] m_pend = 4'h0;
   bit         m_inh = 1'b0;
   int         m_idle_from = 0;
   int         m_hstart = 0;
   int         m_clr_cyc = -1;
   logic [3:0] m_clr_bit = 4'h0;
   int         m_busy_from = BIG;
   int         m_busy_to = 0;
   logic [7:0] m_saved_fl = 8'h20;
   logic [7:0] m_saved_pc = 8'h00;
   logic [7:0] m_last_fv = 8'h20;

   flag_interrupt_ctrl #(
      .PCW(8), .NIRQ(4), .VEC_BASE(8'hF0), .VEC_STRIDE(4)
   ) dut (
      .clk(clk), .reset(reset), .flags(flags), .irq_in(irq_in), .reti(reti),
      .pc_in(pc_in), .stall(stall), .pc_load(pc_load), .pc_out(pc_out),
      .flag_wr(flag_wr), .flag_value(flag_value), .irq_ack(irq_ack), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input int act, input int expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Predict the consequences of the inputs applied in cycle c.
   task automatic model_step(input int c);
      logic [3:0] req;
      int         w;
      ev_t        e;
      if (reset) begin
         m_pend      = 4'h0;
         m_inh       = 1'b0;
         m_idle_from = c + 1;
         m_busy_from = BIG;
         m_busy_to   = c + 1;
         m_clr_cyc   = -1;
         m_last_fv   = 8'h20;
         while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
         return;
      end
      req = m_pend | irq_in;
      if (!m_inh && c >= m_idle_from) begin
         if (flags[4] && req != 4'h0) begin
            w = lowest(req);
            e = '{cyc: c + 1, ack: 4'(1 << w), ld: 1'b0, pc: 8'h00, wr: 1'b0, fv: m_last_fv};
            exp_q.push_back(e);
            m_last_fv = {2'b00, 1'b1, 1'b0, flags[3:0]};
            e = '{cyc: c + 2, ack: 4'h0, ld: 1'b1, pc: 8'((240 + 4 * w) % 256), wr: 1'b1, fv: m_last_fv};
            exp_q.push_back(e);
            m_saved_fl  = flags;
            m_saved_pc  = pc_in;
            m_inh       = 1'b1;
            m_hstart    = c + 3;
            m_busy_from = c + 1;
            m_busy_to   = BIG;
            m_clr_cyc   = c + 1;
            m_clr_bit   = 4'(1 << w);
         end
      end else if (m_inh && c >= m_hstart && reti) begin
         m_last_fv = {2'b00, 1'b1, m_saved_fl[4:0]};
         e = '{cyc: c + 1, ack: 4'h0, ld: 1'b1, pc: m_saved_pc, wr: 1'b1, fv: m_last_fv};
         exp_q.push_back(e);
         m_inh       = 1'b0;
         m_busy_to   = c + 2;
         m_idle_from = c + 2;
      end
      m_pend = (m_pend & ~((c == m_clr_cyc) ? m_clr_bit : 4'h0)) | irq_in;
   endtask

   // One clock cycle: called just after a rising edge; models an external flag register.
   task automatic drive(input logic [3:0] irq_v, input bit reti_v, input bit rst_v,
                        input logic [7:0] pc_v);
      int         c;
      logic       wr_s;
      logic [7:0] val_s;
      c = cyc;
      if (mon_en) st_q.push_back('{cyc: c, busy: (c >= m_busy_from && c < m_busy_to)});
      irq_in = irq_v;
      reti   = reti_v;
      reset  = rst_v;
      pc_in  = pc_v;
      model_step(c);
      @(negedge clk);
      wr_s  = flag_wr;
      val_s = flag_value;
      @(posedge clk);
      #1;
      if (wr_s) flags = val_s;
   endtask

   initial begin : monitor
      int  c;
      bit  ev_here;
      ev_t e;
      st_t s;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            c = cyc;
            while (exp_q.size() > 0 && exp_q[0].cyc < c) begin
               e = exp_q.pop_front();
               tests++; fails++;
               $display("FAIL missed_event: cycle %0d expected ack=%b pc=%h fv=%h never seen", e.cyc, e.ack, e.pc, e.fv);
            end
            ev_here = (exp_q.size() > 0 && exp_q[0].cyc == c);
            if (st_q.size() > 0 && st_q[0].cyc == c) begin
               s = st_q.pop_front();
               tests++;
               if (busy !== s.busy || stall !== ev_here) begin
                  fails++;
                  $display("FAIL status c=%0d: got busy=%b stall=%b expected busy=%b stall=%b", c, busy, stall, s.busy, ev_here);
               end
            end
            if (irq_ack !== 4'h0 || pc_load !== 1'b0 || flag_wr !== 1'b0) begin
               tests++;
               if (!ev_here) begin
                  fails++;
                  $display("FAIL unexpected_event c=%0d: got ack=%b ld=%b pc=%h wr=%b fv=%h expected none", c, irq_ack, pc_load, pc_out, flag_wr, flag_value);
               end else begin
                  e = exp_q.pop_front();
                  if (irq_ack !== e.ack || pc_load !== e.ld || pc_out !== e.pc || flag_wr !== e.wr ||
                      flag_value !== e.fv || stall !== 1'b1) begin
                     fails++;
                     $display("FAIL event c=%0d: got ack=%b ld=%b pc=%h wr=%b fv=%h stall=%b expected ack=%b ld=%b pc=%h wr=%b fv=%h stall=1",
                              c, irq_ack, pc_load, pc_out, flag_wr, flag_value, stall, e.ack, e.ld, e.pc, e.wr, e.fv);
                  end
               end
            end else if (ev_here) begin
               e = exp_q.pop_front();
               tests++; fails++;
               $display("FAIL missing_event c=%0d: got no output expected ack=%b ld=%b pc=%h fv=%h", c, e.ack, e.ld, e.pc, e.fv);
            end
         end
      end
   end

   initial begin : stimulus
      @(posedge clk);
      #1;
      // reset for two cycles with every request line high
      flags = 8'h31;
      drive(4'hF, 1'b0, 1'b1, 8'h00);
      drive(4'hF, 1'b0, 1'b1, 8'h00);
      chk("reset_flag_value", int'(flag_value), 8'h20);
      chk("reset_busy", int'(busy), 0);
      chk("reset_stall", int'(stall), 0);
      chk("reset_irq_ack", int'(irq_ack), 0);
      chk("reset_pc_load", int'(pc_load), 0);
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) drive(4'h0, 1'b0, 1'b0, 8'h10);

      // basic entry and return
      flags = 8'h31;
      drive(4'b0100, 1'b0, 1'b0, 8'h42);
      for (int i = 1; i < 7; i++) drive(4'h0, (i == 3), 1'b0, 8'h42);
      chk("return_flags_restored", int'(flags), 8'h31);

      // masked requests accumulate, then priority order once enabled
      flags = 8'h20;
      drive(4'b1000, 1'b0, 1'b0, 8'h11);
      drive(4'b0000, 1'b0, 1'b0, 8'h11);
      drive(4'b0010, 1'b0, 1'b0, 8'h11);
      drive(4'b0000, 1'b0, 1'b0, 8'h11);
      flags = 8'h30;
      for (int i = 0; i < 12; i++) drive(4'h0, (i == 3 || i == 8), 1'b0, 8'h60 + 8'(i));

      // set-wins on line 0, no nesting for line 1
      flags = 8'h31;
      for (int i = 0; i < 17; i++) begin
         drive((i < 2) ? 4'b0001 : ((i == 3) ? 4'b0010 : 4'b0000),
               (i == 4 || i == 9 || i == 14), 1'b0, 8'h80 + 8'(i));
      end

      // reset in the VECTOR cycle
      flags = 8'h31;
      drive(4'b0001, 1'b0, 1'b0, 8'h33);
      drive(4'b0000, 1'b0, 1'b0, 8'h33);
      drive(4'b0000, 1'b0, 1'b1, 8'h33);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_pc_load", int'(pc_load), 0);
      chk("midreset_flag_wr", int'(flag_wr), 0);
      flags = 8'h31;
      for (int i = 0; i < 4; i++) drive(4'h0, 1'b0, 1'b0, 8'h34);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] irq_r;
         bit         reti_r, rst_r;
         if ($urandom_range(0, 15) == 0) begin
            flags = {2'b00, 6'($urandom)};
            flags[4] = ($urandom_range(0, 9) < 7);
         end
         irq_r  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
         reti_r = m_inh ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
         rst_r  = ($urandom_range(0, 299) == 0);
         drive(irq_r, reti_r, rst_r, 8'($urandom));
      end

      // drain: keep returning until nothing is outstanding
      for (int i = 0; i < 40; i++) drive(4'h0, 1'b1, 1'b0, 8'h00);
      chk("drain_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/flag_interrupt_ctrl.md
Name: flag_interrupt_ctrl

Overview:
Interrupt sequencer; the consumer/reader side of the flag register. Samples the flag vector (I flag, bit 4) and pending interrupt requests, then stalls the core. It snapshots flags and PC, redirects the PC to a vector and rewrites the flag register with I cleared. On RETI it restores the saved PC and flags through the flag register's full-vector load path.

Parameters:
PCW, 8, width of program counter
NIRQ, 4, number of interrupt request lines (index 0 = highest priority)
VEC_BASE, 8'hF0, address of vector 0 (PCW bits)
VEC_STRIDE, 4, address spacing between vectors

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
flags  in  8  current flag vector (Z0 O1 N2 C3 I4 A5, bits 7:6 unused)
irq_in  in  NIRQ  level/pulse interrupt requests, one per line
reti  in  1  one-cycle pulse: RETI instruction decoded this cycle
pc_in  in  PCW  PC of next instruction to execute (return address)
stall  out  1  hold fetch/execute
pc_load  out  1  load pc_out into PC this cycle
pc_out  out  PCW  PC load value
flag_wr  out  1  write flag_value into flag register (full 8-bit load)
flag_value  out  8  flag vector to write
irq_ack  out  NIRQ  one-hot, one-cycle acknowledge of serviced line
busy  out  1  high in every state except IDLE

Behaviour:
- One clock (clk); reset synchronous, active-high; sampled on rising edge, overrides all other activity including mid-sequence.
- Reset: state=IDLE, pending=0, saved_flags=8'h20, saved_pc=0, sel=0; all outputs 0 except flag_value=8'h20.
- pending[NIRQ-1:0]: each edge pending <= (pending & ~clr) | irq_in; clr = one-hot of sel in SAVE. Same-bit set and clear in one cycle: set wins (bit stays 1).
- req = pending | irq_in; winner = lowest set index of req.
- All outputs are decoded from state and internal registers only; no combinational input-to-output path.
- States:
  IDLE: outputs 0. If flags[4]=1 and req!=0: capture saved_flags<=flags, saved_pc<=pc_in, sel<=winner; go SAVE. reti ignored. If flags[4]=0, requests accumulate in pending.
  SAVE (1 cycle): stall=1, irq_ack[sel]=1, pending[sel] cleared; go VECTOR.
  VECTOR (1 cycle): stall=1, pc_load=1, pc_out=VEC_BASE+sel*VEC_STRIDE, truncated to PCW bits (wraps). flag_wr=1, flag_value=saved_flags with bit4=0, bit5=1, bits7:6=0. Go ACTIVE.
  ACTIVE: stall=0, busy=1; handler runs. New irq_in only latch into pending (no nesting). reti=1 -> RESTORE.
  RESTORE (1 cycle): stall=1, pc_load=1, pc_out=saved_pc, flag_wr=1, flag_value=saved_flags with bit5=1, bits7:6=0; go IDLE.
- Latency: irq_in high in cycle N while IDLE with I=1 -> SAVE in N+1, VECTOR (pc_load) in N+2, ACTIVE in N+3.
- After RESTORE, next request is taken in the first IDLE cycle if restored I=1 (back-to-back service; no dead cycle beyond IDLE).
- reti outside ACTIVE: ignored, no state change.
- flag_value holds its last value when flag_wr=0. The flag register must ignore it then.

Test Plan:
- Reset: reset=1 for 2 cycles with irq_in=4'hF -> state IDLE, pending=0, stall=0, irq_ack=0, flag_value=8'h20.
- Basic entry: flags=8'h31, pc_in=8'h42, irq_in=4'b0100 pulse at cycle N -> irq_ack=4'b0100 at N+1; pc_load=1, pc_out=8'hF8, flag_wr=1, flag_value=8'h21 at N+2; stall=0 at N+3.
- Return: in ACTIVE pulse reti -> next cycle pc_load=1, pc_out=8'h42, flag_wr=1, flag_value=8'h31; busy=0 the cycle after.
- Masked and priority: flags=8'h20, irq_in pulses 4'b1000 then 4'b0010 -> no ack; set flags=8'h30 -> ack 4'b0010 first, pc_out=8'hF4; after RETI ack 4'b1000, pc_out=8'hFC.
- Set-wins and no nesting: irq_in[0] held high through SAVE -> pending[0] remains 1; irq_in[1] in ACTIVE -> no ack until after RESTORE, then serviced immediately with restored I=1.
- Reset mid-sequence: assert reset in VECTOR -> next cycle IDLE, pc_load=0, flag_wr=0, pending=0.
